// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_hazard_ctrl_pkg : shared pipeline types and constants for the hazard  |
// |                        sequencer (state encoding, control-field layout)    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } haz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int WB_W = 2;
  localparam int M_W  = 3;
  localparam int EX_W = 4;

  // M field layout is {branch, memread, memwrite}
  localparam int M_MEMREAD_BIT = 1;

  // A source register conflicts with a load destination only when it is not $0
  function automatic logic reg_conflict(input logic [4:0] dst, input logic [4:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

  function automatic logic m_memread(input logic [M_W-1:0] m_field);
    return m_field[M_MEMREAD_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_haz_load_use_det.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | haz_load_use_det : combinational load-use compare of the EX load target    |
// |                    against the ID source registers ($0 never conflicts)    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module haz_load_use_det
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  output logic       hazard
);

  logic w_rs_hit;
  logic w_rt_hit;

  assign w_rs_hit = reg_conflict(idex_rt, ifid_rs);
  assign w_rt_hit = ifid_uses_rt && reg_conflict(idex_rt, ifid_rt);
  assign hazard   = idex_memread && (w_rs_hit || w_rt_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_hazard_ctrl : stall/flush/freeze sequencer for the 5-stage pipeline   |
// | Optional macro HAZ_PERF_CNT_EN adds saturating performance counters.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int WAIT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  input  logic       branch_taken,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_write,
  output logic       idex_bubble,
  output logic       exmem_write,
  output logic       exmem_flush,
  output logic       mem_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_flushes,
  output logic [31:0] perf_mem_wait_cycles
`endif
);

  haz_state_t        r_state;
  haz_state_t        w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic [WAIT_W-1:0] w_wait_cnt_inc;
  logic              r_timeout;
  logic              w_timeout_nxt;
  logic              w_lu_hit;

  haz_load_use_det u_lu_det (
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .hazard       (w_lu_hit)
  );

  assign w_wait_cnt_inc = r_wait_cnt + WAIT_W'(1);
  assign mem_timeout    = r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_nxt  = r_timeout;
    pc_write       = 1'b1;
    ifid_write     = 1'b1;
    ifid_flush     = 1'b0;
    idex_write     = 1'b1;
    idex_bubble    = 1'b0;
    exmem_write    = 1'b1;
    exmem_flush    = 1'b0;

    case (r_state)
      ST_RUN, ST_FLUSH: begin
        if (dmem_req && !dmem_ready) begin
          {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
        end else if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          exmem_flush = 1'b1;
          w_state_nxt = ST_FLUSH;
        end else begin
          // the ID slot after a flush holds a NOP, so no load-use there
          if (r_state == ST_RUN && w_lu_hit) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
          w_state_nxt = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
          w_wait_cnt_nxt = w_wait_cnt_inc;
          if (w_wait_cnt_inc >= WAIT_W'(MEM_WAIT_MAX)) begin
            w_state_nxt   = ST_HALT;
            w_timeout_nxt = 1'b1;
          end
        end else begin
          w_wait_cnt_nxt = '0;
          if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            w_state_nxt = ST_FLUSH;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_HALT: begin
        {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase

    if (rst) begin
      {pc_write, ifid_write, ifid_flush, idex_write} = 4'b0000;
      {idex_bubble, exmem_write, exmem_flush}        = 3'b000;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic w_ev_lu;
  logic w_ev_flush;
  logic w_ev_wait;

  // stall is the only case with a bubble while IF/ID holds
  assign w_ev_lu    = idex_bubble && !ifid_write;
  assign w_ev_flush = ifid_flush;
  assign w_ev_wait  = (r_state == ST_MEM_WAIT) && !dmem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_stalls       <= '0;
      perf_flushes         <= '0;
      perf_mem_wait_cycles <= '0;
    end else begin
      if (w_ev_lu && (perf_lu_stalls != 32'hFFFF_FFFF))
        perf_lu_stalls <= perf_lu_stalls + 32'd1;
      if (w_ev_flush && (perf_flushes != 32'hFFFF_FFFF))
        perf_flushes <= perf_flushes + 32'd1;
      if (w_ev_wait && (perf_mem_wait_cycles != 32'hFFFF_FFFF))
        perf_mem_wait_cycles <= perf_mem_wait_cycles + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : directed self-checking bench for pipe_hazard_ctrl    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  // packed as {pc_w, ifid_w, ifid_fl, idex_w, idex_bub, exmem_w, exmem_fl, timeout}
  localparam logic [7:0] c_run    = 8'b1101_0100;
  localparam logic [7:0] c_stall  = 8'b0001_1100;
  localparam logic [7:0] c_flush  = 8'b1111_1110;
  localparam logic [7:0] c_freeze = 8'b0000_0000;
  localparam logic [7:0] c_halt   = 8'b0000_0001;
  localparam logic [7:0] c_reset  = 8'b0000_0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       idex_memread;
  logic [4:0] idex_rt;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       ifid_uses_rt;
  logic       branch_taken;
  logic       dmem_req;
  logic       dmem_ready;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_write;
  logic       idex_bubble;
  logic       exmem_write;
  logic       exmem_flush;
  logic       mem_timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_WAIT_MAX(16), .WAIT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .branch_taken (branch_taken),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_bubble  (idex_bubble),
    .exmem_write  (exmem_write),
    .exmem_flush  (exmem_flush),
    .mem_timeout  (mem_timeout)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic apply(input logic mr, input logic [4:0] xrt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ur, input logic br,
                       input logic rq, input logic rd);
    idex_memread = mr;
    idex_rt      = xrt;
    ifid_rs      = rs;
    ifid_rt      = rt;
    ifid_uses_rt = ur;
    branch_taken = br;
    dmem_req     = rq;
    dmem_ready   = rd;
  endtask

  task automatic idle();
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // inputs change 1 after the edge; outputs are sampled mid-cycle
  task automatic step_chk(input string tag, input logic [7:0] exp);
    #4;
    check_eq(tag, {pc_write, ifid_write, ifid_flush, idex_write,
                   idex_bubble, exmem_write, exmem_flush, mem_timeout}, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step_chk("reset_outputs", c_reset);
    rst = 1'b0;
    step_chk("run_default", c_run);

    apply(1'b1, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    step_chk("lu_rs_stall", c_stall);
    apply(1'b0, 5'd8, 5'd8, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    step_chk("lu_after_bubble", c_run);

    apply(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step_chk("lu_reg0", c_run);
    apply(1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    step_chk("lu_rt_unused", c_run);
    apply(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    step_chk("lu_rt_used", c_stall);
    idle();
    step_chk("lu_clear", c_run);

    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    step_chk("branch_flush", c_flush);
    apply(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step_chk("flush_no_lu", c_run);
    step_chk("post_flush_lu", c_stall);
    idle();
    step_chk("post_flush_clear", c_run);

    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step_chk($sformatf("mw_freeze%0d", i), c_freeze);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step_chk("mw_release_flush", c_flush);
    idle();
    step_chk("mw_after_flush", c_run);
    step_chk("mw_back_run", c_run);

    // 16 not-ready cycles: the 16th is still frozen, then HALT
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step_chk($sformatf("to_wait%0d", i), c_freeze);
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    step_chk("halt_0", c_halt);
    idle();
    step_chk("halt_1", c_halt);
    rst = 1'b1;
    step_chk("halt_reset", c_reset);
    rst = 1'b0;
    step_chk("halt_exit_run", c_run);

    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step_chk("mid_wait_c1", c_freeze);
    rst = 1'b1;
    step_chk("mid_wait_reset", c_reset);
    rst = 1'b0;
    idle();
    step_chk("mid_wait_run", c_run);

    // counter must restart: 15 more frozen cycles must not reach HALT
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) step_chk($sformatf("rs_wait%0d", i), c_freeze);
    idle();
    step_chk("rs_release", c_run);
    step_chk("rs_run", c_run);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
